// File: rtl/noekeon_pkg.sv
// Noekeon primitives shared by the iterative core: round transforms, RC stepping,
// FSM encoding. Word i of a block (a_i) lives in bits [32*i +: 32].
package noekeon_pkg;

    typedef logic [3:0][31:0] blk_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] RC_ENC_INIT = 8'h80;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic blk_t theta(input blk_t k, input blk_t a);
        blk_t        r;
        logic [31:0] t;
        r    = a;
        t    = r[0] ^ r[2];
        t    = t ^ rotl(t, 8) ^ rotl(t, 24);
        r[1] = r[1] ^ t;
        r[3] = r[3] ^ t;
        r    = r ^ k;
        t    = r[1] ^ r[3];
        t    = t ^ rotl(t, 8) ^ rotl(t, 24);
        r[0] = r[0] ^ t;
        r[2] = r[2] ^ t;
        return r;
    endfunction

    function automatic blk_t pi1(input blk_t a);
        return {rotl(a[3], 2), rotl(a[2], 5), rotl(a[1], 1), a[0]};
    endfunction

    function automatic blk_t pi2(input blk_t a);
        return {rotl(a[3], 30), rotl(a[2], 27), rotl(a[1], 31), a[0]};
    endfunction

    function automatic blk_t gamma(input blk_t a);
        blk_t        r;
        logic [31:0] t;
        r    = a;
        r[1] = r[1] ^ (~r[3] & ~r[2]);
        r[0] = r[0] ^ (r[2] & r[1]);
        t    = r[3];
        r[3] = r[0];
        r[0] = t;
        r[2] = r[2] ^ r[0] ^ r[1] ^ r[3];
        r[1] = r[1] ^ (~r[3] & ~r[2]);
        r[0] = r[0] ^ (r[2] & r[1]);
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return {1'b0, x[7:1]} ^ (x[0] ? 8'h8D : 8'h00);
    endfunction

    // Decryption walks the RC sequence backwards, so it starts from RC[nround].
    function automatic logic [7:0] rc_dec_init(input int nround);
        logic [7:0] rc;
        rc = RC_ENC_INIT;
        for (int i = 0; i < nround; i++) rc = xtime(rc);
        return rc;
    endfunction

endpackage

// File: rtl/noekeon_round.sv
// One combinational Noekeon round; mode selects where RC enters (before or after Theta).
module noekeon_round
    import noekeon_pkg::*;
(
    input  blk_t       a_in,
    input  blk_t       k,
    input  logic [7:0] rc_in,
    input  logic       mode,
    output blk_t       a_out,
    output logic [7:0] rc_out
);

    blk_t a_mix;

    always_comb begin
        a_mix = a_in;
        if (mode) begin
            a_mix    = theta(k, a_mix);
            a_mix[0] = a_mix[0] ^ {24'd0, rc_in};
        end else begin
            a_mix[0] = a_mix[0] ^ {24'd0, rc_in};
            a_mix    = theta(k, a_mix);
        end
    end

    assign a_out  = pi2(gamma(pi1(a_mix)));
    assign rc_out = mode ? inv_xtime(rc_in) : xtime(rc_in);

endmodule

// File: rtl/noekeon_iter.sv
// Iterative Noekeon encrypt/decrypt (direct-key mode), UNROLL rounds per clock,
// valid/ready handshakes on both sides.
module noekeon_iter
    import noekeon_pkg::*;
#(
    parameter int NROUND = 16,
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int         NCYC        = NROUND / UNROLL;
    localparam logic [5:0] CNT_LAST    = 6'(NCYC);
    localparam logic [7:0] RC_DEC_INIT = rc_dec_init(NROUND);

    state_t     state, state_nx;
    blk_t       st, wk, fin;
    logic [7:0] rc;
    logic       md;
    logic [5:0] cnt;

    blk_t       chain_a  [UNROLL+1];
    logic [7:0] chain_rc [UNROLL+1];

    assign chain_a[0]  = st;
    assign chain_rc[0] = rc;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        noekeon_round u_round (
            .a_in   (chain_a[g]),
            .k      (wk),
            .rc_in  (chain_rc[g]),
            .mode   (md),
            .a_out  (chain_a[g+1]),
            .rc_out (chain_rc[g+1])
        );
    end

    // Output transform mirrors the round's RC/Theta ordering for each direction.
    always_comb begin
        fin = st;
        if (md) begin
            fin    = theta(wk, fin);
            fin[0] = fin[0] ^ {24'd0, rc};
        end else begin
            fin[0] = fin[0] ^ {24'd0, rc};
            fin    = theta(wk, fin);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_RUN;
            end
            S_RUN:  if (cnt == CNT_LAST) state_nx = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // cnt counts completed round cycles; the cycle with cnt == NCYC only finalises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= '0;
            wk       <= '0;
            rc       <= '0;
            md       <= 1'b0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    st  <= blk_t'(data_in);
                    wk  <= mode ? theta('0, blk_t'(key)) : blk_t'(key);
                    rc  <= mode ? RC_DEC_INIT : RC_ENC_INIT;
                    md  <= mode;
                    cnt <= '0;
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        data_out <= fin;
                    end else begin
                        st  <= chain_a[UNROLL];
                        rc  <= chain_rc[UNROLL];
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noekeon_iter.sv
// Bench for noekeon_iter: three instances (UNROLL 1/2/4) against a behavioural
// Noekeon model, with directed handshake and reset sequences.
module tb_noekeon_iter;

    localparam int           NR     = 16;
    localparam logic [127:0] KAT_CT = 128'h503d2dfc_24b70148_699e29fa_b1656851;
    localparam logic [127:0] ONES   = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         mode      [3];
    logic [127:0] key_s     [3];
    logic [127:0] din       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] dout      [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] exp_q [$];
    int           acc_q [$];

    typedef struct packed {
        logic         md;
        logic [127:0] k;
        logic [127:0] d;
        logic [127:0] exp;
    } vec_t;
    vec_t tv [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        noekeon_iter #(.NROUND(NR), .UNROLL(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mode      (mode[g]),
            .key       (key_s[g]),
            .data_in   (din[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (dout[g])
        );
    end

    // Reference model: word i of a block is bits [32*i +: 32].
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] mtheta(input logic [127:0] kk, input logic [127:0] aa);
        logic [31:0] w0, w1, w2, w3, t;
        {w3, w2, w1, w0} = aa;
        t  = w0 ^ w2;
        t  = t ^ rl(t, 8) ^ rl(t, 24);
        w1 = w1 ^ t;
        w3 = w3 ^ t;
        w0 = w0 ^ kk[31:0];
        w1 = w1 ^ kk[63:32];
        w2 = w2 ^ kk[95:64];
        w3 = w3 ^ kk[127:96];
        t  = w1 ^ w3;
        t  = t ^ rl(t, 8) ^ rl(t, 24);
        w0 = w0 ^ t;
        w2 = w2 ^ t;
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] mround(input bit dec, input logic [127:0] kk,
                                            input logic [127:0] aa, input logic [7:0] c);
        logic [127:0] x;
        logic [31:0]  w0, w1, w2, w3, t;
        x = aa;
        if (!dec) x[7:0] = x[7:0] ^ c;
        x = mtheta(kk, x);
        if (dec) x[7:0] = x[7:0] ^ c;
        {w3, w2, w1, w0} = x;
        w1 = rl(w1, 1);
        w2 = rl(w2, 5);
        w3 = rl(w3, 2);
        w1 = w1 ^ (~w3 & ~w2);
        w0 = w0 ^ (w2 & w1);
        t  = w3;
        w3 = w0;
        w0 = t;
        w2 = w2 ^ w0 ^ w1 ^ w3;
        w1 = w1 ^ (~w3 & ~w2);
        w0 = w0 ^ (w2 & w1);
        w1 = rl(w1, 31);
        w2 = rl(w2, 27);
        w3 = rl(w3, 30);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [127:0] ref_cipher(input bit dec, input logic [127:0] kin,
                                                input logic [127:0] din_v);
        logic [7:0]   rcs [NR+1];
        logic [127:0] kk, x;
        rcs[0] = 8'h80;
        for (int i = 1; i <= NR; i++)
            rcs[i] = {rcs[i-1][6:0], 1'b0} ^ (rcs[i-1][7] ? 8'h1b : 8'h00);
        kk = dec ? mtheta('0, kin) : kin;
        x  = din_v;
        for (int r = 0; r < NR; r++) x = mround(dec, kk, x, dec ? rcs[NR-r] : rcs[r]);
        if (dec) begin
            x      = mtheta(kk, x);
            x[7:0] = x[7:0] ^ rcs[0];
        end else begin
            x[7:0] = x[7:0] ^ rcs[NR];
            x      = mtheta(kk, x);
        end
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int lat_of(input int u);
        return NR / (1 << u) + 1;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string what, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", what, act, req);
        end
    endtask

    task automatic scramble(input int u);
        mode[u]  = 1'($urandom_range(1));
        key_s[u] = rnd128();
        din[u]   = rnd128();
    endtask

    task automatic single_op(input int u, input logic md, input logic [127:0] k,
                             input logic [127:0] d, input logic [127:0] req, input string tag);
        int n;
        int t_acc;
        n = 0;
        while (!in_ready[u] && n < 40) begin tick(); n++; end
        chk({tag, " ready"}, in_ready[u], 1'b1);
        in_valid[u] = 1'b1;
        mode[u]     = md;
        key_s[u]    = k;
        din[u]      = d;
        exp_q.push_back(req);
        t_acc = cyc + 1;
        tick();
        in_valid[u] = 1'b0;
        n = 0;
        while (!out_valid[u] && n < 64) begin scramble(u); tick(); n++; end
        chk({tag, " latency"}, cyc - t_acc, lat_of(u));
        chk({tag, " data"}, dout[u], exp_q.pop_front());
        tick();
    endtask

    // Back-to-back random traffic with out_ready held high; expectations queued at accept.
    task automatic stream(input int u, input int n);
        int sent, got, guard, last_acc, lat;
        sent = 0; got = 0; guard = 0; last_acc = -1; lat = lat_of(u);
        out_ready[u] = 1'b1;
        while (got < n && guard < n * (lat + 2) + 200) begin
            in_valid[u] = (sent < n);
            scramble(u);
            if (out_valid[u]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("u%0d unexpected out_valid", u), out_valid[u], 1'b0);
                end else begin
                    chk($sformatf("u%0d stream %0d data", u, got), dout[u], exp_q.pop_front());
                    chk($sformatf("u%0d stream %0d latency", u, got), cyc - acc_q.pop_front(), lat);
                end
                got++;
            end
            if (in_valid[u] && in_ready[u]) begin
                exp_q.push_back(ref_cipher(mode[u], key_s[u], din[u]));
                acc_q.push_back(cyc + 1);
                if (last_acc >= 0)
                    chk($sformatf("u%0d period %0d", u, sent), cyc + 1 - last_acc, lat + 2);
                last_acc = cyc + 1;
                sent++;
            end
            tick();
            guard++;
        end
        in_valid[u] = 1'b0;
        chk($sformatf("u%0d stream results", u), got, n);
        exp_q.delete();
        acc_q.delete();
    endtask

    initial begin
        logic [127:0] k1, d1, e;
        int           n, t_acc, pulses;

        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; mode[u] = 1'b0; key_s[u] = '0; din[u] = '0;
            out_ready[u] = 1'b1;
        end

        k1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        d1 = 128'h01234567_89abcdef_fedcba98_76543210;
        tv[0] = '{md: 1'b0, k: '0,   d: '0,     exp: KAT_CT};
        tv[1] = '{md: 1'b1, k: '0,   d: KAT_CT, exp: '0};
        tv[2] = '{md: 1'b0, k: ONES, d: ONES,   exp: ref_cipher(1'b0, ONES, ONES)};
        tv[3] = '{md: 1'b1, k: ONES, d: tv[2].exp, exp: ONES};
        tv[4] = '{md: 1'b0, k: k1,   d: d1,     exp: ref_cipher(1'b0, k1, d1)};
        tv[5] = '{md: 1'b1, k: k1,   d: tv[4].exp, exp: d1};
        tv[6] = '{md: 1'b1, k: d1,   d: k1,     exp: ref_cipher(1'b1, d1, k1)};

        // Reset state
        repeat (3) tick();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset out_valid", u), out_valid[u], 1'b0);
            chk($sformatf("u%0d reset in_ready", u), in_ready[u], 1'b1);
            chk($sformatf("u%0d reset data_out", u), dout[u], '0);
        end
        rst = 1'b0;
        tick();

        for (int u = 0; u < 3; u++)
            for (int i = 0; i < 7; i++)
                single_op(u, tv[i].md, tv[i].k, tv[i].d, tv[i].exp, $sformatf("u%0d vec%0d", u, i));

        // Stall in DONE with in_valid noise during RUN and DONE
        e = ref_cipher(1'b0, k1, ONES);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; mode[0] = 1'b0; key_s[0] = k1; din[0] = ONES;
        t_acc = cyc + 1;
        tick();
        n = 0;
        while (!out_valid[0] && n < 64) begin scramble(0); tick(); n++; end
        chk("hold latency", cyc - t_acc, 17);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold %0d data", i), dout[0], e);
            chk($sformatf("hold %0d in_ready", i), in_ready[0], 1'b0);
            chk($sformatf("hold %0d out_valid", i), out_valid[0], 1'b1);
            scramble(0);
            tick();
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("hold retire out_valid", out_valid[0], 1'b0);
        chk("hold retire in_ready", in_ready[0], 1'b1);

        // Asynchronous reset in the middle of RUN
        in_valid[0] = 1'b1; mode[0] = 1'b0; key_s[0] = k1; din[0] = d1;
        tick();
        in_valid[0] = 1'b0;
        repeat (8) tick();
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid[0], 1'b0);
        chk("async rst in_ready", in_ready[0], 1'b1);
        chk("async rst data_out", dout[0], '0);
        tick();
        rst = 1'b0;
        tick();
        chk("post rst in_ready", in_ready[0], 1'b1);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid[0]) pulses++;
            tick();
        end
        chk("post rst out_valid pulses", pulses, 0);
        single_op(0, 1'b1, d1, KAT_CT, ref_cipher(1'b1, d1, KAT_CT), "post rst op");

        for (int u = 0; u < 3; u++) stream(u, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
